// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and data bundle between a conversion requester and bin_to_bcd_seq.
// The requester drives bin_in/start; the converter returns status and the BCD result.
interface bin_to_bcd_seq_if;
  logic [13:0] bin_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  modport master (
    output bin_in,
    output start,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  modport slave (
    input  bin_in,
    input  start,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble, one bit per clock).
// Inputs above 9999 saturate to 9999 and raise overflow with the result.
module bin_to_bcd_seq (
  input logic              clock,
  input logic              reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam logic [1:0]  StIdle  = 2'd0;
  localparam logic [1:0]  StShift = 2'd1;
  localparam logic [1:0]  StDone  = 2'd2;
  localparam logic [13:0] MaxVal  = 14'd9999;
  localparam logic [3:0]  LastBit = 4'd13;

  logic [1:0]  state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [15:0] acc_adj;
  logic [29:0] shifted;
  logic        in_ovf;

  // Per-nibble add-3 with no carry between digits.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The accumulator MSB is dropped; it cannot be set for inputs <= 9999.
  assign shifted = {acc_adj[14:0], bin_q, 1'b0};
  assign in_ovf  = (bus.bin_in > MaxVal);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          bin_d      = in_ovf ? MaxVal : bus.bin_in;
          acc_d      = 16'h0000;
          cnt_d      = 4'd0;
          ovf_pend_d = in_ovf;
          state_d    = StShift;
        end
      end
      StShift: begin
        acc_d = shifted[29:14];
        bin_d = shifted[13:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastBit) begin
          bcd_d   = shifted[29:14];
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bin_q      <= 14'd0;
      acc_q      <= 16'h0000;
      cnt_q      <= 4'd0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= 16'h0000;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == StShift);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
